// File: rtl/ps2_kbd_rx_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    localparam int FRAME_BITS = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// CPU-side keyboard register interface: pop handshake, head byte and status flags.
interface ps2_kbd_rx_if;
    import ps2_pkg::*;

    logic       done;
    logic       ovf_clr;
    logic       rdy;
    logic [7:0] data;
    logic       err;
    logic       ovf;

    modport master (output done, ovf_clr, input rdy, data, err, ovf);
    modport slave  (input done, ovf_clr, output rdy, data, err, ovf);
endinterface

// File: rtl/ps2_kbd_rx_line_filter.sv
// Two-flop synchroniser followed by a hysteretic run-length filter for one PS/2 line.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt
);
    localparam int CW = clog2(FILTER_LEN);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] cnt;

    // Lines idle high, so everything presets to 1 to avoid a false edge after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            cnt     <= '0;
            filt    <= 1'b1;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            // cnt tracks consecutive samples that disagree with the filtered level
            if (sync_p1 == filt) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                filt <= sync_p1;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 device-to-host receiver with byte FIFO. Optional clock inhibit when nearly full: PS2_INHIBIT_EN.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 25000000,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 2000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ps2c,
    input  logic         ps2d,
    output logic         ps2c_low,
    ps2_kbd_rx_if.slave  bus
);
    localparam int TO_CYC = (CLK_HZ / 1000000) * TIMEOUT_US;
    localparam int TW     = clog2(TO_CYC);
    localparam int BW     = clog2(FRAME_BITS);
    localparam int AW     = clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    logic c_filt, d_filt, c_prev, fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk(clk), .rst(rst), .raw(ps2c), .filt(c_filt)
    );
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
        .clk(clk), .rst(rst), .raw(ps2d), .filt(d_filt)
    );

    ps2_state_e      state;
    logic [BW-1:0]   bitcnt;
    logic [TW-1:0]   tmo_cnt;
    logic [7:0]      shreg;
    logic            par;
    logic            err_r;
    logic            push;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            ovf_r;
    logic            pop, full, do_push, ovf_set;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) c_prev <= 1'b1;
        else      c_prev <= c_filt;
    end

`ifdef PS2_INHIBIT_EN
    localparam logic [AW:0] NEAR_CNT = (AW + 1)'(FIFO_DEPTH - 1);
    logic inh;

    // Only asserted from IDLE, so a frame already on the wire always completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) inh <= 1'b0;
        else      inh <= (count >= NEAR_CNT) && (state == ST_IDLE);
    end

    assign ps2c_low = inh;
    assign fall     = c_prev & ~c_filt & ~inh;
`else
    assign ps2c_low = 1'b0;
    assign fall     = c_prev & ~c_filt;
`endif

    // ---- Stage: frame deframer ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            bitcnt  <= '0;
            tmo_cnt <= '0;
            err_r   <= 1'b0;
            push    <= 1'b0;
        end else begin
            err_r <= 1'b0;
            push  <= 1'b0;
            if (fall) begin
                tmo_cnt <= '0;
                case (state)
                    ST_IDLE: begin
                        if (!d_filt) begin
                            state  <= ST_DATA;
                            bitcnt <= '0;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == BW'(FRAME_BITS - 1)) state <= ST_PARITY;
                    end
                    ST_PARITY: state <= ST_STOP;
                    ST_STOP: begin
                        // odd parity over data plus parity bit, stop bit must be 1
                        if (d_filt && ((^shreg) ^ par)) push  <= 1'b1;
                        else                            err_r <= 1'b1;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (state != ST_IDLE) begin
                if (tmo_cnt == TW'(TO_CYC - 1)) begin
                    state   <= ST_IDLE;
                    err_r   <= 1'b1;
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fall && state == ST_DATA)   shreg <= {d_filt, shreg[7:1]};
        if (fall && state == ST_PARITY) par   <= d_filt;
    end

    // ---- Stage: byte FIFO ----
    assign full    = (count == FULL_CNT);
    assign pop     = bus.done && (count != '0);
    assign do_push = push && (!full || pop);
    assign ovf_set = push && full && !pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_r  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (ovf_set)          ovf_r <= 1'b1;
            else if (bus.ovf_clr) ovf_r <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shreg;
    end

    assign bus.rdy  = (count != '0);
    assign bus.data = (count != '0) ? mem[rd_ptr] : 8'h00;
    assign bus.err  = err_r;
    assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx: drives PS/2 frames and pops the FIFO against a byte queue.
module tb_ps2_kbd_rx;
    import ps2_pkg::*;

    localparam int HALF  = 20;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ps2c = 1'b1;
    logic ps2d = 1'b1;
    logic ps2c_low;

    ps2_kbd_rx_if bus ();

    ps2_kbd_rx #(
        .CLK_HZ(25000000), .FILTER_LEN(8), .TIMEOUT_US(20), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .ps2c(ps2c), .ps2d(ps2d), .ps2c_low(ps2c_low), .bus(bus)
    );

    always #20 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int err_cnt     = 0;
    logic [7:0] q[$];

    always @(posedge clk) if (rst && bus.err === 1'b1) err_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par);
        return {1'b1, ~(^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2d = frame[i];
            repeat (HALF) @(negedge clk);
            ps2c = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2c = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic expect_push);
        send_bits(make_frame(b, bad_par), 11);
        repeat (HALF) @(negedge clk);
        ps2d = 1'b1;
        if (expect_push) q.push_back(b);
        repeat (30) @(negedge clk);
    endtask

    task automatic pop_one(input string tag);
        logic [7:0] exp;
        int n;
        n = 0;
        while (bus.rdy !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rdy"}, bus.rdy, 1);
        exp = (q.size() != 0) ? q.pop_front() : 8'hxx;
        chk(tag, bus.data, exp);
        bus.done = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
    endtask

    initial begin
        int e0;
        logic seen;
        bus.done    = 1'b0;
        bus.ovf_clr = 1'b0;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_rdy", bus.rdy, 0);
        chk("rst_data", bus.data, 8'h00);
        chk("rst_err", bus.err, 0);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_inh", ps2c_low, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // single good frame
        e0 = err_cnt;
        send_byte(8'h1C, 1'b0, 1'b1);
        pop_one("good_1c");
        @(negedge clk);
        chk("good_empty", bus.rdy, 0);
        chk("good_noerr", err_cnt - e0, 0);

        // parity error then good frame
        e0 = err_cnt;
        send_byte(8'h1C, 1'b1, 1'b0);
        chk("par_err", err_cnt - e0, 1);
        chk("par_rdy", bus.rdy, 0);
        send_byte(8'hF0, 1'b0, 1'b1);
        pop_one("after_par_f0");

        // timeout after 4 bits (timeout = 500 cycles here)
        e0 = err_cnt;
        send_bits(make_frame(8'h33, 1'b0), 4);
        ps2d = 1'b1;
        repeat (300) @(negedge clk);
        chk("tmo_early", err_cnt - e0, 0);
        repeat (325) @(negedge clk);
        chk("tmo_err", err_cnt - e0, 1);
        send_byte(8'h5A, 1'b0, 1'b1);
        pop_one("after_tmo_5a");
        chk("tmo_total_err", err_cnt - e0, 1);

        // overflow: 17 bytes, last one dropped
        for (int i = 1; i <= 17; i++)
            send_byte(8'(i), 1'b0, (i <= DEPTH));
        chk("ovf_set", bus.ovf, 1);
        for (int i = 0; i < DEPTH; i++) pop_one("ovf_pop");
        @(negedge clk);
        chk("ovf_empty", bus.rdy, 0);
        chk("ovf_sticky", bus.ovf, 1);
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        chk("ovf_clr", bus.ovf, 0);

        // full FIFO with pop in the push cycle
        for (int i = 0; i < DEPTH; i++) send_byte(8'h20 + 8'(i), 1'b0, 1'b1);
        seen = 1'b0;
        fork
            send_byte(8'h30, 1'b0, 1'b1);
            begin
                for (int n = 0; n < 2000; n++) begin
                    @(negedge clk);
                    if (dut.push === 1'b1) begin
                        seen = 1'b1;
                        break;
                    end
                end
                if (seen) begin
                    chk("full_head", bus.data, q.pop_front());
                    bus.done = 1'b1;
                    @(negedge clk);
                    bus.done = 1'b0;
                    chk("full_ovf", bus.ovf, 0);
                end else begin
                    chk("full_push_seen", seen, 1);
                end
            end
        join
        for (int i = 0; i < DEPTH; i++) pop_one("full_pop");
        @(negedge clk);
        chk("full_empty", bus.rdy, 0);
        chk("full_ovf_end", bus.ovf, 0);

        // short glitches on ps2c while idle
        e0 = err_cnt;
        for (int i = 0; i < 4; i++) begin
            ps2c = 1'b0;
            repeat (3) @(negedge clk);
            ps2c = 1'b1;
            repeat (20) @(negedge clk);
        end
        chk("glitch_err", err_cnt - e0, 0);
        chk("glitch_rdy", bus.rdy, 0);
        send_byte(8'h3C, 1'b0, 1'b1);
        pop_one("glitch_3c");

        // reset mid-frame with a byte buffered
        send_byte(8'h77, 1'b0, 1'b0);
        send_bits(make_frame(8'h99, 1'b0), 5);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_rdy", bus.rdy, 0);
        chk("mid_rst_data", bus.data, 8'h00);
        chk("mid_rst_err", bus.err, 0);
        chk("mid_rst_ovf", bus.ovf, 0);
        ps2d = 1'b1;
        rst  = 1'b1;
        q.delete();
        repeat (10) @(negedge clk);
        send_byte(8'hA5, 1'b0, 1'b1);
        pop_one("post_rst_a5");
        @(negedge clk);
        chk("post_rst_empty", bus.rdy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
